// File: rtl/serial_comparator_if.sv
// Serial comparator bus: operand bit stream in, status and result flags out.
interface serial_comparator_if;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic eq;
    logic gt;
    logic lt;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator, MSB first. The first differing bit decides
// the result; later differences are ignored. Result flags are registered and
// held until the next accepted start.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, result flags held
// ST_SHIFT | frame in progress, accepting operand bits (busy=1)
// ST_DONE  | single-cycle result strobe (done=1), start here restarts
module serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_comparator_if.slave   bus
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          decided;
    logic          a_wins;

    logic          accept;
    logic          decided_next;
    logic          a_wins_next;

    // Bit acceptance and first-difference capture; start always overrides a bit.
    always_comb begin
        accept       = (state == ST_SHIFT) && bus.bit_valid && !bus.start;
        decided_next = decided;
        a_wins_next  = a_wins;
        if (accept && !decided && (bus.a_bit ^ bus.b_bit)) begin
            decided_next = 1'b1;
            a_wins_next  = bus.a_bit;
        end
    end

    // Frame sequencing with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            decided  <= 1'b0;
            a_wins   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.eq   <= 1'b0;
            bus.gt   <= 1'b0;
            bus.lt   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state    <= ST_SHIFT;
                        bus.busy <= 1'b1;
                        count    <= '0;
                        decided  <= 1'b0;
                        a_wins   <= 1'b0;
                        bus.eq   <= 1'b0;
                        bus.gt   <= 1'b0;
                        bus.lt   <= 1'b0;
                    end else begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bus.start) begin
                        // Abort: restart the frame in place, the current bit is dropped.
                        count   <= '0;
                        decided <= 1'b0;
                        a_wins  <= 1'b0;
                    end else if (accept) begin
                        decided <= decided_next;
                        a_wins  <= a_wins_next;
                        if (count == LAST) begin
                            state    <= ST_DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            count    <= '0;
                            bus.eq   <= !decided_next;
                            bus.gt   <= decided_next && a_wins_next;
                            bus.lt   <= decided_next && !a_wins_next;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: three instances (WIDTH 2, 8, 32) share one
// serial stream. A per-frame arithmetic model predicts when each instance
// reports and what it reports; a negedge monitor records what really happens.
module tb_serial_comparator;

    logic clk;
    logic rst_n;
    logic start, bit_valid, a_bit, b_bit;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ws [3]      = '{2, 8, 32};

    logic [34:0] obs_q [3][$];
    logic [34:0] exp_q [3][$];

    serial_comparator_if if2 ();
    serial_comparator_if if8 ();
    serial_comparator_if if32 ();

    assign if2.start      = start;
    assign if2.bit_valid  = bit_valid;
    assign if2.a_bit      = a_bit;
    assign if2.b_bit      = b_bit;
    assign if8.start      = start;
    assign if8.bit_valid  = bit_valid;
    assign if8.a_bit      = a_bit;
    assign if8.b_bit      = b_bit;
    assign if32.start     = start;
    assign if32.bit_valid = bit_valid;
    assign if32.a_bit     = a_bit;
    assign if32.b_bit     = b_bit;

    serial_comparator #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
    serial_comparator #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_comparator #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Record every done strobe; flags must be clear while busy and busy low while done.
    always @(negedge clk) begin
        if (if2.done)  obs_q[0].push_back({32'(cyc), if2.eq,  if2.gt,  if2.lt});
        if (if8.done)  obs_q[1].push_back({32'(cyc), if8.eq,  if8.gt,  if8.lt});
        if (if32.done) obs_q[2].push_back({32'(cyc), if32.eq, if32.gt, if32.lt});
        check("flags_in_shift_or_busy_in_done",
              {if2.busy  & (if2.eq  | if2.gt  | if2.lt),
               if8.busy  & (if8.eq  | if8.gt  | if8.lt),
               if32.busy & (if32.eq | if32.gt | if32.lt),
               if2.done & if2.busy, if8.done & if8.busy, if32.done & if32.busy}, 0);
    end

    // Compare the leading w bits of two nbits-wide operands as plain numbers.
    function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input int nbits, input int w);
        longint unsigned av, bv, m;
        m  = (64'd1 << w) - 1;
        av = (64'(a) >> (nbits - w)) & m;
        bv = (64'(b) >> (nbits - w)) & m;
        if (av == bv)     return 3'b100;
        else if (av > bv) return 3'b010;
        else              return 3'b001;
    endfunction

    function automatic logic [8:0] all_flags();
        return {if2.eq, if2.gt, if2.lt, if8.eq, if8.gt, if8.lt, if32.eq, if32.gt, if32.lt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_idle(input int n);
        start     = 1'b0;
        bit_valid = 1'b0;
        repeat (n) begin
            a_bit = 1'($urandom);
            b_bit = 1'($urandom);
            step();
        end
    endtask

    // Start a frame, then send nsend of the nbits operand bits MSB first with
    // gmin..gmax stall cycles before each bit.
    task automatic drive_frame(input logic [31:0] a, input logic [31:0] b,
                               input int nbits, input int nsend,
                               input int gmin, input int gmax);
        start     = 1'b1;
        bit_valid = 1'($urandom);
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        step();
        check("busy_after_start", {if2.busy, if8.busy, if32.busy}, 3'b111);
        check("flags_clear_after_start", all_flags(), 0);
        for (int k = 1; k <= nsend; k++) begin
            repeat ($urandom_range(gmax, gmin)) begin
                start     = 1'b0;
                bit_valid = 1'b0;
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
                step();
            end
            start     = 1'b0;
            bit_valid = 1'b1;
            a_bit     = a[nbits - k];
            b_bit     = b[nbits - k];
            for (int j = 0; j < 3; j++)
                if (k == ws[j]) exp_q[j].push_back({32'(cyc + 1), model(a, b, nbits, ws[j])});
            step();
        end
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic drain();
        logic [34:0] o, e;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("w%0d_done_count", ws[j]), obs_q[j].size(), exp_q[j].size());
            while (obs_q[j].size() > 0 && exp_q[j].size() > 0) begin
                o = obs_q[j].pop_front();
                e = exp_q[j].pop_front();
                check($sformatf("w%0d_done_cycle", ws[j]), o[34:3], e[34:3]);
                check($sformatf("w%0d_result", ws[j]), o[2:0], e[2:0]);
            end
            obs_q[j].delete();
            exp_q[j].delete();
        end
    endtask

    initial begin
        logic [31:0] a, b;
        int r;
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        #12;
        check("reset_outputs", {if2.busy, if2.done, if8.busy, if8.done, if32.busy, if32.done,
                                all_flags()}, 0);
        rst_n = 1'b1;
        step_idle(2);

        // equal operands
        drive_frame(32'hA5, 32'hA5, 8, 8, 0, 0);
        step_idle(2);
        drain();
        check("w8_eq_held", {if8.eq, if8.gt, if8.lt}, 3'b100);

        // early decision, result held through idle time
        drive_frame(32'h80, 32'h7F, 8, 8, 0, 0);
        step_idle(20);
        drain();
        check("w8_gt_held_20", {if8.eq, if8.gt, if8.lt}, 3'b010);

        // late decision with fixed 3-cycle stalls
        drive_frame(32'h12, 32'h13, 8, 8, 3, 3);
        step_idle(2);
        drain();

        // abort after 4 bits, then a full frame
        drive_frame(32'hF0, 32'h00, 8, 4, 0, 0);
        drive_frame(32'h01, 32'h02, 8, 8, 0, 0);
        step_idle(2);
        drain();
        check("w8_lt_after_restart", {if8.eq, if8.gt, if8.lt}, 3'b001);

        // 32-bit equal and early-decision frames
        drive_frame(32'hA5A5A5A5, 32'hA5A5A5A5, 32, 32, 0, 0);
        step_idle(2);
        drain();
        drive_frame(32'h80000000, 32'h7FFFFFFF, 32, 32, 0, 0);
        step_idle(20);
        drain();
        check("all_gt_held_20", all_flags(), 9'b010_010_010);

        // async reset between edges with results held
        #3 rst_n = 1'b0;
        #1 check("async_rst_idle", {if2.busy, if8.busy, if32.busy, all_flags()}, 0);
        #10 rst_n = 1'b1;
        step_idle(1);

        // async reset mid-frame, then bits without start must be ignored
        drive_frame(32'h55, 32'hAA, 8, 3, 0, 0);
        #3 rst_n = 1'b0;
        #1 check("async_rst_midframe", {if2.busy, if8.busy, if32.busy, if2.done, if8.done,
                                         if32.done, all_flags()}, 0);
        #10 rst_n = 1'b1;
        step_idle(1);
        repeat (8) begin
            bit_valid = 1'b1;
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            step();
        end
        step_idle(3);
        drain();
        check("no_start_no_busy", {if2.busy, if8.busy, if32.busy}, 0);

        // back-to-back: second start lands in the DONE cycle of the 8-bit instance
        drive_frame(32'h40, 32'h41, 8, 8, 0, 0);
        drive_frame(32'hC3, 32'h3C, 8, 8, 0, 1);
        step_idle(2);
        drain();

        // randomized 32-bit frames, some back-to-back
        for (int n = 0; n < 16; n++) begin
            a = $urandom;
            r = $urandom_range(0, 3);
            case (r)
                0:       b = a;
                1:       b = a ^ 32'h1;
                2:       b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            drive_frame(a, b, 32, 32, 0, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                step_idle(2);
                drain();
            end
        end
        step_idle(2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
